// File: rtl/uart_tx_engine.sv
// uart_tx_engine: 8N1 UART transmitter with write FIFO,
// baud divider and serializer FSM.
module uart_tx_engine #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tx_wen,
  input  logic [7:0]                    uart_din,
  output logic                          tx_full,
  output logic                          tx_empty,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   tx_count,
  output logic                          tx_overflow,
  output logic                          tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic            push, pop, baud_end;

  assign push     = tx_wen && !full_q;
  assign pop      = (state_q == IDLE) && !empty_q;
  assign baud_end = (baud_q == BW'(CLKS_PER_BIT - 1));

  // FIFO pointers, occupancy, flags and sticky overflow
  always_comb begin
    wr_d  = push ? wr_q + AW'(1) : wr_q;
    rd_d  = pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    full_d  = (cnt_d == CW'(FIFO_DEPTH));
    empty_d = (cnt_d == '0);
    ovf_d   = ovf_q | (tx_wen & full_q);
  end

  // Serializer next state: start, 8 data bits LSB first, stop
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        bit_d  = '0;
        if (!empty_q) begin
          shift_d = mem_q[rd_q];
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        baud_d = baud_q + BW'(1);
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = DATA;
        end
      end
      DATA: begin
        baud_d = baud_q + BW'(1);
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      STOP: begin
        baud_d = baud_q + BW'(1);
        if (baud_end) begin
          baud_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= uart_din;
  end

  assign tx          = tx_q;
  assign tx_busy     = (state_q != IDLE);
  assign tx_full     = full_q;
  assign tx_empty    = empty_q;
  assign tx_count    = cnt_q;
  assign tx_overflow = ovf_q;
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: vector table, directed corner cases and
// random traffic against a frame-timeline reference model.
module tb_uart_tx_engine;
  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_wen = 1'b0;
  logic [7:0] uart_din = 8'h00;
  logic       tx_full, tx_empty, tx_busy, tx_overflow, tx;
  logic [3:0] tx_count;

  uart_tx_engine #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .tx_wen(tx_wen), .uart_din(uart_din),
    .tx_full(tx_full), .tx_empty(tx_empty), .tx_busy(tx_busy),
    .tx_count(tx_count), .tx_overflow(tx_overflow), .tx(tx)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a byte queue plus the start edge of the
  // frame in flight; the line level follows from arithmetic.
  logic [7:0] mq[$];
  bit         m_ovf = 1'b0;
  longint     n = 0;
  longint     t0 = -1000;
  logic [7:0] cur = 8'h00;
  bit         m_idle, m_full, m_emp;
  bit         chk_en = 1'b0;

  // decoder state
  logic [7:0] rxq[$];
  bit         dec_act = 1'b0;
  int         dec_cnt = 0;
  logic [7:0] dec_b = 8'h00;
  logic       prev_tx = 1'b1;

  always @(posedge clk) begin
    n++;
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
      t0 = -1000;
      dec_act = 1'b0;
    end else begin
      m_idle = (n >= t0 + FRAME + 1);
      m_full = (mq.size() == DEPTH);
      m_emp  = (mq.size() == 0);
      if (m_idle && !m_emp) begin
        cur = mq.pop_front();
        t0 = n;
      end
      if (tx_wen) begin
        if (m_full) m_ovf = 1'b1;
        else mq.push_back(uart_din);
      end
    end
  end

  longint m_k;
  int     m_idx;
  logic   e_tx, e_busy;

  always @(negedge clk) begin
    if (chk_en) begin
      m_k = n - t0;
      if (m_k >= 0 && m_k < FRAME) begin
        e_busy = 1'b1;
        m_idx = int'(m_k / CPB);
        if (m_idx == 0) e_tx = 1'b0;
        else if (m_idx <= 8) e_tx = cur[m_idx-1];
        else e_tx = 1'b1;
      end else begin
        e_busy = 1'b0;
        e_tx = 1'b1;
      end
      check("model_tx", tx, e_tx);
      check("model_busy", tx_busy, e_busy);
      check("model_count", tx_count, mq.size());
      check("model_full", tx_full, mq.size() == DEPTH);
      check("model_empty", tx_empty, mq.size() == 0);
      check("model_ovf", tx_overflow, m_ovf);
      // serial decoder, samples mid-bit
      if (!dec_act) begin
        if (tx === 1'b0 && prev_tx === 1'b1) begin
          dec_act = 1'b1;
          dec_cnt = 0;
        end
      end else begin
        dec_cnt++;
        if (dec_cnt % CPB == CPB / 2 && dec_cnt / CPB >= 1 &&
            dec_cnt / CPB <= 8)
          dec_b[dec_cnt/CPB-1] = tx;
        if (dec_cnt == 9 * CPB + CPB / 2) begin
          check("stop_bit", tx, 1);
          rxq.push_back(dec_b);
          dec_act = 1'b0;
        end
      end
      prev_tx = tx;
    end
  end

  typedef struct {
    int         cyc;
    logic       tx;
    logic       busy;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl[15];

  task automatic cyc(int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wr(logic [7:0] b);
    tx_wen = 1'b1;
    uart_din = b;
    @(negedge clk);
    tx_wen = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(int lim);
    int i = 0;
    while ((tx_busy !== 1'b0 || tx_empty !== 1'b1) && i < lim) begin
      @(negedge clk);
      i++;
    end
    check("wait_idle_in_time", i < lim, 1);
  endtask

  initial begin
    int c;
    int i;
    bit ok;
    logic [7:0] exp_rx[$];

    tbl[0]  = '{0,  1'b1, 1'b0, 4'd1};
    tbl[1]  = '{1,  1'b0, 1'b1, 4'd0};
    tbl[2]  = '{4,  1'b0, 1'b1, 4'd0};
    tbl[3]  = '{5,  1'b1, 1'b1, 4'd0};
    tbl[4]  = '{9,  1'b0, 1'b1, 4'd0};
    tbl[5]  = '{13, 1'b1, 1'b1, 4'd0};
    tbl[6]  = '{17, 1'b0, 1'b1, 4'd0};
    tbl[7]  = '{21, 1'b0, 1'b1, 4'd0};
    tbl[8]  = '{25, 1'b1, 1'b1, 4'd0};
    tbl[9]  = '{29, 1'b0, 1'b1, 4'd0};
    tbl[10] = '{33, 1'b1, 1'b1, 4'd0};
    tbl[11] = '{36, 1'b1, 1'b1, 4'd0};
    tbl[12] = '{37, 1'b1, 1'b1, 4'd0};
    tbl[13] = '{40, 1'b1, 1'b1, 4'd0};
    tbl[14] = '{41, 1'b1, 1'b0, 4'd0};

    rst_n = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    rst_n = 1'b1;
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_full", tx_full, 0);
    check("rst_empty", tx_empty, 1);
    check("rst_count", tx_count, 0);
    check("rst_ovf", tx_overflow, 0);

    // single 0xA5 frame against the vector table
    tx_wen = 1'b1;
    uart_din = 8'hA5;
    @(negedge clk);
    tx_wen = 1'b0;
    c = 0;
    foreach (tbl[k]) begin
      while (c < tbl[k].cyc) begin
        @(negedge clk);
        c++;
      end
      check($sformatf("a5_tx_c%0d", tbl[k].cyc), tx, tbl[k].tx);
      check($sformatf("a5_busy_c%0d", tbl[k].cyc), tx_busy, tbl[k].busy);
      check($sformatf("a5_cnt_c%0d", tbl[k].cyc), tx_count, tbl[k].cnt);
    end
    wait_idle(200);

    // ten back-to-back writes, last one overflows
    rxq.delete();
    for (int b = 0; b < 10; b++) begin
      tx_wen = 1'b1;
      uart_din = 8'(b);
      @(negedge clk);
      if (b == 1) check("burst_busy_after_e1", tx_busy, 1);
      if (b == 8) begin
        check("burst_count8", tx_count, 8);
        check("burst_full", tx_full, 1);
        check("burst_no_ovf_yet", tx_overflow, 0);
      end
      if (b == 9) begin
        check("burst_ovf", tx_overflow, 1);
        check("burst_count_kept", tx_count, 8);
      end
    end
    tx_wen = 1'b0;

    // write on the same edge as a pop from a full FIFO
    i = 0;
    while (tx_busy !== 1'b0 && i < 100) begin
      @(negedge clk);
      i++;
    end
    check("full_pop_wait", i < 100, 1);
    check("full_before_pop", tx_full, 1);
    tx_wen = 1'b1;
    uart_din = 8'hEE;
    @(negedge clk);
    check("full_pop_count7", tx_count, 7);
    check("full_pop_ovf", tx_overflow, 1);
    check("full_pop_notfull", tx_full, 0);
    uart_din = 8'hEF;
    @(negedge clk);
    tx_wen = 1'b0;
    check("refill_count8", tx_count, 8);
    check("refill_full", tx_full, 1);
    wait_idle(1000);
    exp_rx.delete();
    for (int b = 0; b < 9; b++) exp_rx.push_back(8'(b));
    exp_rx.push_back(8'hEF);
    check("burst_rx_len", rxq.size(), exp_rx.size());
    foreach (exp_rx[k])
      if (k < rxq.size()) check($sformatf("burst_rx%0d", k), rxq[k], exp_rx[k]);

    // reset during data bit 3 with three bytes queued
    do_reset();
    for (int b = 0; b < 4; b++) wr(8'h50 + 8'(b));
    check("mid_count3", tx_count, 3);
    cyc(15);
    check("mid_busy", tx_busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", tx_busy, 0);
    check("mid_rst_count", tx_count, 0);
    check("mid_rst_empty", tx_empty, 1);
    check("mid_rst_ovf", tx_overflow, 0);
    ok = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) ok = 1'b0;
    end
    check("mid_rst_quiet", ok, 1);

    // spaced writes across pointer wrap
    rxq.delete();
    exp_rx.delete();
    ok = 1'b1;
    for (int b = 0; b < 20; b++) begin
      wr(8'h30 + 8'(b));
      exp_rx.push_back(8'h30 + 8'(b));
      if (tx_count > 4'd8) ok = 1'b0;
      cyc($urandom_range(30, 45));
    end
    wait_idle(2000);
    check("wrap_count_le8", ok, 1);
    check("wrap_no_ovf", tx_overflow, 0);
    check("wrap_rx_len", rxq.size(), 20);
    foreach (exp_rx[k])
      if (k < rxq.size()) check($sformatf("wrap_rx%0d", k), rxq[k], exp_rx[k]);

    // idle line
    do_reset();
    ok = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_count !== 4'd0) ok = 1'b0;
    end
    check("idle_1000", ok, 1);

    // random traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      tx_wen = ($urandom_range(0, 99) < ((k / 500) % 2 == 0 ? 4 : 20));
      uart_din = 8'($urandom);
      rst_n = ($urandom_range(0, 599) != 0);
      @(negedge clk);
    end
    tx_wen = 1'b0;
    rst_n = 1'b1;
    wait_idle(1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
